sdram_arbit: RTL and testbench
==============================

SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter: NOP_CMD, 4'b0111, idle command {cs_n,ras_n,cas_n,we_n} driven in ARBIT.
REQ-002 Parameter: DQ_W, 16, SDRAM data bus width.
REQ-003 sys_clk  in  1  system clock, 100 MHz; the only clock.
REQ-004 sys_rst  in  1  asynchronous, active-high reset.
REQ-005 init_end  in  1  initialisation done; sticky high once set.
REQ-006 init_cmd/init_ba/init_addr  in  4/2/13  command bundle from the init block.
REQ-007 aref_req  in  1  auto-refresh request, held until service starts.
REQ-008 aref_end  in  1  one-cycle pulse marking the end of refresh.
REQ-009 aref_cmd/aref_ba/aref_addr  in  4/2/13  refresh command bundle.
REQ-010 aref_en  out  1  refresh grant.
REQ-011 wr_req/wr_end  in  1/1  write request and one-cycle end pulse.
REQ-012 wr_cmd/wr_ba/wr_addr  in  4/2/13  write command bundle.
REQ-013 wr_sdram_en/wr_data  in  1/DQ_W  write data-drive enable and write data.
REQ-014 wr_en  out  1  write grant.
REQ-015 rd_req/rd_end  in  1/1  read request and one-cycle end pulse.
REQ-016 rd_cmd/rd_ba/rd_addr  in  4/2/13  read command bundle.
REQ-017 rd_en  out  1  read grant.
REQ-018 sdram_cs_n/ras_n/cas_n/we_n  out  1 each  SDRAM command pins.
REQ-019 sdram_ba/sdram_addr  out  2/13  SDRAM bank and address pins.
REQ-020 sdram_dq  inout  DQ_W  SDRAM data bus.

Function
REQ-021 The FSM SHALL have the states IDLE, ARBIT, AREF, WRITE and READ; any illegal encoding SHALL go to IDLE.
REQ-022 IDLE: the FSM SHALL move to ARBIT on the first edge at which init_end=1.
REQ-023 ARBIT: the FSM SHALL grant by fixed priority, with aref_req above all other requests. Between wr_req and rd_req it SHALL use round-robin: a registered last_wr flag gives READ priority when last_wr=1 and both requests are pending.
REQ-024 On the edge ARBIT->AREF/WRITE/READ, the FSM SHALL set the matching *_en register to 1, and SHALL set last_wr=1 for WRITE and last_wr=0 for READ.
REQ-025 The FSM SHALL hold each *_en until its *_end is sampled high. On that edge *_en SHALL clear and the FSM SHALL return to ARBIT.
REQ-026 At most one of aref_en, wr_en and rd_en SHALL be high at any time.
REQ-027 After any *_end, the FSM SHALL spend at least one ARBIT cycle, driving NOP, before the next grant. A request already pending at *_end SHALL be granted on the following edge.
REQ-028 Requests arriving during service SHALL wait; they SHALL NOT be pre-empted or lost.
REQ-029 An *_end pulse whose source is not granted SHALL be ignored.
REQ-030 The command mux SHALL be combinational from the state:
- IDLE -> init_*
- AREF -> aref_*
- WRITE -> wr_*
- READ -> rd_*
- ARBIT -> NOP_CMD, ba=2'b11, addr=13'h1fff
REQ-031 sdram_dq SHALL equal wr_data when wr_sdram_en=1 and state=WRITE; otherwise it SHALL be high-Z.

Reset
REQ-032 On sys_rst=1, state=IDLE and aref_en=wr_en=rd_en=0 SHALL take effect asynchronously.
REQ-033 On sys_rst=1, last_wr SHALL reset to 0 (write wins the first wr/rd tie).
REQ-034 Under reset, the SDRAM pins SHALL follow init_*, and sdram_dq SHALL be high-Z.
REQ-035 Reset mid-service SHALL drop the grant immediately; the source's late *_end SHALL then be ignored.

Structure
REQ-036 The state encodings, NOP_CMD and the idle ba/addr constants SHALL live in the shared sdram_pkg, together with the command codes used by the refresh/read/write blocks.
REQ-037 The block SHALL be a single module with no sub-module; the mux and FSM are small enough to keep flat.

Verification
REQ-038 Reset release with init_end rising at cycle 20: IDLE until cycle 20; pins equal init_*; ARBIT at cycle 21.
REQ-039 aref_req, wr_req and rd_req raised in the same cycle: aref_en is asserted first. After aref_end, wr_en follows after 1 NOP cycle; after wr_end, rd_en follows after 1 NOP cycle.
REQ-040 wr_req and rd_req held continuously: grants alternate W, R, W, R; never two consecutive writes.
REQ-041 aref_req raised during WRITE: no pre-emption; aref_en asserts 2 edges after wr_end, even with wr_req still high.
REQ-042 sys_rst pulsed during READ, then a stray rd_end: rd_en=0 immediately; the FSM stays in IDLE/ARBIT and issues no grant from the stray pulse.
REQ-043 In WRITE with wr_sdram_en=1 and wr_data=16'hA5C3: sdram_dq=16'hA5C3. In READ and ARBIT: sdram_dq=Z.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller constants: arbiter states and command codes.
// Command codes are {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } arb_state_t;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_MREG  = 4'b0000;
  localparam logic [3:0] CMD_BST   = 4'b0110;

  localparam logic [1:0]  IDLE_BA   = 2'b11;
  localparam logic [12:0] IDLE_ADDR = 13'h1fff;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: refresh first, write/read round-robin,
// and the command/data mux onto the SDRAM pins.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter logic [3:0] NOP_CMD = CMD_NOP,
  parameter int         DQ_W    = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            init_end,
  input  logic [3:0]      init_cmd,
  input  logic [1:0]      init_ba,
  input  logic [12:0]     init_addr,
  input  logic            aref_req,
  input  logic            aref_end,
  input  logic [3:0]      aref_cmd,
  input  logic [1:0]      aref_ba,
  input  logic [12:0]     aref_addr,
  output logic            aref_en,
  input  logic            wr_req,
  input  logic            wr_end,
  input  logic [3:0]      wr_cmd,
  input  logic [1:0]      wr_ba,
  input  logic [12:0]     wr_addr,
  input  logic            wr_sdram_en,
  input  logic [DQ_W-1:0] wr_data,
  output logic            wr_en,
  input  logic            rd_req,
  input  logic            rd_end,
  input  logic [3:0]      rd_cmd,
  input  logic [1:0]      rd_ba,
  input  logic [12:0]     rd_addr,
  output logic            rd_en,
  output logic            sdram_cs_n,
  output logic            sdram_ras_n,
  output logic            sdram_cas_n,
  output logic            sdram_we_n,
  output logic [1:0]      sdram_ba,
  output logic [12:0]     sdram_addr,
  inout  wire  [DQ_W-1:0] sdram_dq
);

  arb_state_t state, state_nxt;
  logic aref_en_nxt, wr_en_nxt, rd_en_nxt;
  logic last_wr, last_wr_nxt;
  logic [3:0] cmd;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      last_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      aref_en <= aref_en_nxt;
      wr_en   <= wr_en_nxt;
      rd_en   <= rd_en_nxt;
      last_wr <= last_wr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    aref_en_nxt = aref_en;
    wr_en_nxt   = wr_en;
    rd_en_nxt   = rd_en;
    last_wr_nxt = last_wr;
    case (state)
      IDLE: begin
        if (init_end) state_nxt = ARBIT;
      end
      ARBIT: begin
        // last_wr hands a wr/rd tie to the read side
        if (aref_req) begin
          state_nxt   = AREF;
          aref_en_nxt = 1'b1;
        end else if (wr_req && !(rd_req && last_wr)) begin
          state_nxt   = WRITE;
          wr_en_nxt   = 1'b1;
          last_wr_nxt = 1'b1;
        end else if (rd_req) begin
          state_nxt   = READ;
          rd_en_nxt   = 1'b1;
          last_wr_nxt = 1'b0;
        end
      end
      AREF: begin
        if (aref_end) begin
          state_nxt   = ARBIT;
          aref_en_nxt = 1'b0;
        end
      end
      WRITE: begin
        if (wr_end) begin
          state_nxt = ARBIT;
          wr_en_nxt = 1'b0;
        end
      end
      READ: begin
        if (rd_end) begin
          state_nxt = ARBIT;
          rd_en_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        aref_en_nxt = 1'b0;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    cmd        = NOP_CMD;
    sdram_ba   = IDLE_BA;
    sdram_addr = IDLE_ADDR;
    case (state)
      IDLE: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  assign sdram_dq = (wr_sdram_en && state == WRITE) ? wr_data
                                                     : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: transaction-level owner model
// checked every cycle, plus hand-computed grant/pin expectations.
module tb_sdram_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic [3:0]  init_cmd  = 4'b0010;
  logic [1:0]  init_ba   = 2'b01;
  logic [12:0] init_addr = 13'h0400;
  logic        aref_req, aref_end;
  logic [3:0]  aref_cmd  = 4'b0001;
  logic [1:0]  aref_ba   = 2'b10;
  logic [12:0] aref_addr = 13'h0aaa;
  logic        aref_en;
  logic        wr_req, wr_end;
  logic [3:0]  wr_cmd    = 4'b0100;
  logic [1:0]  wr_ba     = 2'b01;
  logic [12:0] wr_addr   = 13'h0123;
  logic        wr_sdram_en;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        rd_req, rd_end;
  logic [3:0]  rd_cmd    = 4'b0101;
  logic [1:0]  rd_ba     = 2'b10;
  logic [12:0] rd_addr   = 13'h0456;
  logic        rd_en;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  wire  [15:0] sdram_dq;

  // a released bus reads back as all ones
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (sdram_dq[i]);
  end

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
    .aref_ba(aref_ba), .aref_addr(aref_addr), .aref_en(aref_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd),
    .wr_ba(wr_ba), .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en),
    .wr_data(wr_data), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd),
    .rd_ba(rd_ba), .rd_addr(rd_addr), .rd_en(rd_en),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq(sdram_dq)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // owner: 0 nobody (arbitrating), 1 refresh, 2 write, 3 read
  int owner = 0;
  bit up = 1'b0;
  bit last_w = 1'b0;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      owner = 0; up = 1'b0; last_w = 1'b0;
    end else if (!up) begin
      up = init_end;
    end else if (owner == 0) begin
      if (aref_req) owner = 1;
      else if (wr_req && rd_req) owner = last_w ? 3 : 2;
      else if (wr_req) owner = 2;
      else if (rd_req) owner = 3;
      if (owner == 2) last_w = 1'b1;
      if (owner == 3) last_w = 1'b0;
    end else if ((owner == 1 && aref_end) || (owner == 2 && wr_end) ||
                 (owner == 3 && rd_end)) begin
      owner = 0;
    end
  end

  function automatic logic [63:0] exp_vec();
    logic [2:0]  g;
    logic [18:0] p;
    logic [15:0] d;
    g = (owner == 1) ? 3'b100 : (owner == 2) ? 3'b010 :
        (owner == 3) ? 3'b001 : 3'b000;
    if (!up)             p = {init_cmd, init_ba, init_addr};
    else if (owner == 1) p = {aref_cmd, aref_ba, aref_addr};
    else if (owner == 2) p = {wr_cmd, wr_ba, wr_addr};
    else if (owner == 3) p = {rd_cmd, rd_ba, rd_addr};
    else                 p = {4'b0111, 2'b11, 13'h1fff};
    d = (up && owner == 2 && wr_sdram_en) ? wr_data : 16'hffff;
    return {26'd0, g, p, d};
  endfunction

  function automatic logic [63:0] act_vec();
    return {26'd0, aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n,
            sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr, sdram_dq};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  always @(negedge sys_clk) if (chk_on) chk("cycle", act_vec(), exp_vec());

  function automatic logic [2:0] gnt();
    return {aref_en, wr_en, rd_en};
  endfunction

  function automatic logic [18:0] pins();
    return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
            sdram_ba, sdram_addr};
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic pulse(input int k);
    if (k == 1) aref_end = 1'b1;
    if (k == 2) wr_end = 1'b1;
    if (k == 3) rd_end = 1'b1;
    step();
    aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
  endtask

  task automatic wait_grant(output logic [2:0] g);
    int n = 0;
    while (gnt() == 3'b000 && n < 6) begin
      step();
      n++;
    end
    g = gnt();
  endtask

  localparam logic [18:0] NOP_PINS = {4'b0111, 2'b11, 13'h1fff};

  logic [2:0] g;

  initial begin
    sys_rst = 1'b0; init_end = 1'b0;
    aref_req = 1'b0; aref_end = 1'b0;
    wr_req = 1'b0; wr_end = 1'b0; wr_sdram_en = 1'b0; wr_data = 16'h0;
    rd_req = 1'b0; rd_end = 1'b0;
    #1 sys_rst = 1'b1;
    chk_on = 1'b1;
    repeat (3) step();
    chk("reset_grants", {61'd0, gnt()}, 64'd0);
    chk("reset_pins", {45'd0, pins()}, {45'd0, 4'b0010, 2'b01, 13'h0400});
    chk("reset_dq", {48'd0, sdram_dq}, 64'hffff);
    sys_rst = 1'b0;

    // init completes at cycle 20
    repeat (20) step();
    init_end = 1'b1;
    #1 chk("idle_pins", {45'd0, pins()}, {45'd0, init_cmd, init_ba, init_addr});
    step();
    chk("arbit_nop", {45'd0, pins()}, {45'd0, NOP_PINS});

    // three-way tie: refresh, then write, then read
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step();
    chk("tie_aref", {61'd0, gnt()}, 64'b100);
    aref_req = 1'b0;
    step(); step();
    pulse(1);
    chk("gap_after_aref", {42'd0, gnt(), pins()}, {42'd0, 3'b000, NOP_PINS});
    step();
    chk("tie_wr", {61'd0, gnt()}, 64'b010);
    wr_req = 1'b0; wr_sdram_en = 1'b1; wr_data = 16'ha5c3;
    #1 chk("wr_dq", {48'd0, sdram_dq}, 64'ha5c3);
    step();
    pulse(2);
    chk("arbit_dq", {48'd0, sdram_dq}, 64'hffff);
    step();
    chk("tie_rd", {61'd0, gnt()}, 64'b001);
    #1 chk("rd_dq", {48'd0, sdram_dq}, 64'hffff);
    wr_sdram_en = 1'b0; rd_req = 1'b0;
    step();
    pulse(3);

    // continuous write/read requests alternate starting with write
    wr_req = 1'b1; rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      chk("rr_grant", {61'd0, g}, (k % 2 == 0) ? 64'b010 : 64'b001);
      step();
      pulse(g == 3'b010 ? 2 : (g == 3'b001 ? 3 : 1));
    end

    // refresh raised mid-write waits for the write to end
    wait_grant(g);
    chk("pre_aref_wr", {61'd0, g}, 64'b010);
    aref_req = 1'b1;
    step(); step();
    chk("no_preempt", {61'd0, gnt()}, 64'b010);
    pulse(2);
    chk("aref_gap", {61'd0, gnt()}, 64'b000);
    step();
    chk("aref_after_wr", {61'd0, gnt()}, 64'b100);
    aref_req = 1'b0;
    step();
    pulse(1);
    step();
    chk("rd_after_aref", {61'd0, gnt()}, 64'b001);
    wr_req = 1'b0; rd_req = 1'b0;

    // reset mid-read, then a stray read end
    step();
    sys_rst = 1'b1;
    #1 chk("rst_async", {42'd0, gnt(), pins()},
           {42'd0, 3'b000, init_cmd, init_ba, init_addr});
    step();
    sys_rst = 1'b0;
    pulse(3);
    step(); step();
    chk("stray_end", {42'd0, gnt(), pins()}, {42'd0, 3'b000, NOP_PINS});

    @(negedge sys_clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
